tx_rd_req_arbiter: RTL and testbench

- Shares the single memory-read request TLP path between two requesters:
  - the primary DMA read-chunk requester;
  - the retry monitor's re-issue requester.
- Owns the read-tag pool: allocates a free tag to each primary request and frees it when the completion path reports the transfer finished.
- Sits between the DMA read engine / retry monitor and the TX TLP builder.

---
 rtl/tx_rd_req_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_tx_rd_req_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rd_req_arbiter.sv
// tx_rd_req_arbiter
// Shares the memory-read request TLP path between the primary DMA read-chunk
// requester and the retry monitor, and owns the read-tag pool.
//
// Optional build macro: TX_RD_ARB_STATS_EN enables the retry_grants /
// primary_grants counters; without it both ports are tied to zero.
//
// Ports:
//   trn_clk, reset                    clock, async active-high reset
//   read_chunk / _ack, tlp_tag        primary request handshake, allocated tag
//   huge_page_addr_read_from,
//   qwords_to_rd                      primary address and length (QW)
//   retry_read_chunk / _ack           retry request handshake
//   retry_huge_page_addr_read_from,
//   retry_tlp_tag, retry_dwords_to_rd retry address, tag, length (DW)
//   tag_release, tag_release_num      completion path frees a tag
//   rd_req/_addr/_tag/_dw, rd_req_ack request to the TLP builder
//   tags_free, release_err            pool occupancy, sticky bad-release flag
//   retry_grants, primary_grants      optional statistics counters
module tx_rd_req_arbiter #(
  parameter int unsigned NUM_TAGS     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        read_chunk,
  input  logic [63:0] huge_page_addr_read_from,
  input  logic [8:0]  qwords_to_rd,
  output logic        read_chunk_ack,
  output logic [3:0]  tlp_tag,
  input  logic        retry_read_chunk,
  input  logic [63:0] retry_huge_page_addr_read_from,
  input  logic [3:0]  retry_tlp_tag,
  input  logic [9:0]  retry_dwords_to_rd,
  output logic        retry_read_chunk_ack,
  input  logic        tag_release,
  input  logic [3:0]  tag_release_num,
  output logic        rd_req,
  output logic [63:0] rd_req_addr,
  output logic [3:0]  rd_req_tag,
  output logic [9:0]  rd_req_dw,
  input  logic        rd_req_ack,
  output logic [4:0]  tags_free,
  output logic        release_err,
  output logic [31:0] retry_grants,
  output logic [31:0] primary_grants
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, GUARD} state_t;

  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [63:0]         addr_q, addr_d;
  logic [3:0]          tag_q, tag_d;
  logic [9:0]          dw_q, dw_d;
  logic                win_retry_q, win_retry_d;
  logic                prim_ack_q, prim_ack_d;
  logic                retry_ack_q, retry_ack_d;
  logic [3:0]          tlp_tag_q, tlp_tag_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [4:0]          tags_free_q, tags_free_d;
  logic                release_err_q, release_err_d;
  logic [7:0]          starve_q, starve_d;

  logic                free_found;
  logic [3:0]          free_idx;
  logic                prim_elig;
  logic                retry_elig;
  logic                alloc;
  logic                rel_hit;
  logic [4:0]          busy_cnt;

  // Arbitration FSM, tag pool and starvation bookkeeping
  always_comb begin
    state_d       = state_q;
    rd_req_d      = rd_req_q;
    addr_d        = addr_q;
    tag_d         = tag_q;
    dw_d          = dw_q;
    win_retry_d   = win_retry_q;
    prim_ack_d    = 1'b0;
    retry_ack_d   = 1'b0;
    tlp_tag_d     = tlp_tag_q;
    busy_d        = busy_q;
    release_err_d = release_err_q;
    starve_d      = starve_q;
    alloc         = 1'b0;
    rel_hit       = 1'b0;
    free_found    = 1'b0;
    free_idx      = 4'd0;
    busy_cnt      = 5'd0;

    // Descending scan so the lowest free index wins
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end

    prim_elig  = read_chunk && free_found;
    retry_elig = retry_read_chunk;

    case (state_q)
      IDLE: begin
        if (retry_elig && ((starve_q < 8'(STARVE_LIMIT)) || !prim_elig)) begin
          state_d     = ISSUE;
          rd_req_d    = 1'b1;
          win_retry_d = 1'b1;
          addr_d      = retry_huge_page_addr_read_from;
          tag_d       = retry_tlp_tag;
          dw_d        = retry_dwords_to_rd;
          // Only count retry wins that actually held off an eligible primary
          if (prim_elig && (starve_q != 8'hFF)) starve_d = starve_q + 8'd1;
        end else if (prim_elig) begin
          state_d     = ISSUE;
          rd_req_d    = 1'b1;
          win_retry_d = 1'b0;
          addr_d      = huge_page_addr_read_from;
          tag_d       = free_idx;
          dw_d        = {qwords_to_rd, 1'b0};
          starve_d    = 8'd0;
        end
      end
      ISSUE: begin
        if (rd_req_ack) begin
          rd_req_d = 1'b0;
          state_d  = ACK;
          if (win_retry_q) begin
            retry_ack_d = 1'b1;
          end else begin
            prim_ack_d = 1'b1;
            tlp_tag_d  = tag_q;
            alloc      = 1'b1;
          end
        end
      end
      ACK:     state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Release: only a currently busy, in-range tag is freed
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (tag_release && (tag_release_num == 4'(i)) && busy_q[i]) begin
        busy_d[i] = 1'b0;
        rel_hit   = 1'b1;
      end
    end
    if (tag_release && !rel_hit) release_err_d = 1'b1;

    // Allocation commits on the edge the primary ack is raised
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (alloc && (tag_q == 4'(i))) busy_d[i] = 1'b1;
    end

    for (int i = 0; i < NUM_TAGS; i++) begin
      busy_cnt = busy_cnt + 5'(busy_d[i]);
    end
    tags_free_d = 5'(NUM_TAGS) - busy_cnt;
  end

  // State and output registers
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_req_q      <= 1'b0;
      addr_q        <= 64'd0;
      tag_q         <= 4'd0;
      dw_q          <= 10'd0;
      win_retry_q   <= 1'b0;
      prim_ack_q    <= 1'b0;
      retry_ack_q   <= 1'b0;
      tlp_tag_q     <= 4'd0;
      busy_q        <= '0;
      tags_free_q   <= 5'(NUM_TAGS);
      release_err_q <= 1'b0;
      starve_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      rd_req_q      <= rd_req_d;
      addr_q        <= addr_d;
      tag_q         <= tag_d;
      dw_q          <= dw_d;
      win_retry_q   <= win_retry_d;
      prim_ack_q    <= prim_ack_d;
      retry_ack_q   <= retry_ack_d;
      tlp_tag_q     <= tlp_tag_d;
      busy_q        <= busy_d;
      tags_free_q   <= tags_free_d;
      release_err_q <= release_err_d;
      starve_q      <= starve_d;
    end
  end

  assign rd_req               = rd_req_q;
  assign rd_req_addr          = addr_q;
  assign rd_req_tag           = tag_q;
  assign rd_req_dw            = dw_q;
  assign read_chunk_ack       = prim_ack_q;
  assign retry_read_chunk_ack = retry_ack_q;
  assign tlp_tag              = tlp_tag_q;
  assign tags_free            = tags_free_q;
  assign release_err          = release_err_q;

`ifdef TX_RD_ARB_STATS_EN
  logic [31:0] retry_grants_q, retry_grants_d;
  logic [31:0] primary_grants_q, primary_grants_d;

  // Grant statistics, counted on the ack pulse; wrap naturally
  always_comb begin
    retry_grants_d   = retry_grants_q;
    primary_grants_d = primary_grants_q;
    if (retry_ack_d) retry_grants_d   = retry_grants_q + 32'd1;
    if (prim_ack_d)  primary_grants_d = primary_grants_q + 32'd1;
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      retry_grants_q   <= 32'd0;
      primary_grants_q <= 32'd0;
    end else begin
      retry_grants_q   <= retry_grants_d;
      primary_grants_q <= primary_grants_d;
    end
  end

  assign retry_grants   = retry_grants_q;
  assign primary_grants = primary_grants_q;
`else
  assign retry_grants   = 32'd0;
  assign primary_grants = 32'd0;
`endif

endmodule

// File: tb/tb_tx_rd_req_arbiter.sv
// Directed self-checking bench for tx_rd_req_arbiter (NUM_TAGS = 4,
// STARVE_LIMIT = 2 so the fairness pattern is short).
module tb_tx_rd_req_arbiter;

  logic        trn_clk;
  logic        reset;
  logic        read_chunk;
  logic [63:0] huge_page_addr_read_from;
  logic [8:0]  qwords_to_rd;
  logic        read_chunk_ack;
  logic [3:0]  tlp_tag;
  logic        retry_read_chunk;
  logic [63:0] retry_huge_page_addr_read_from;
  logic [3:0]  retry_tlp_tag;
  logic [9:0]  retry_dwords_to_rd;
  logic        retry_read_chunk_ack;
  logic        tag_release;
  logic [3:0]  tag_release_num;
  logic        rd_req;
  logic [63:0] rd_req_addr;
  logic [3:0]  rd_req_tag;
  logic [9:0]  rd_req_dw;
  logic        rd_req_ack;
  logic [4:0]  tags_free;
  logic        release_err;
  logic [31:0] retry_grants;
  logic [31:0] primary_grants;

  int vectors;
  int miscompares;

  tx_rd_req_arbiter #(.NUM_TAGS(4), .STARVE_LIMIT(2)) dut (
    .trn_clk                        (trn_clk),
    .reset                          (reset),
    .read_chunk                     (read_chunk),
    .huge_page_addr_read_from       (huge_page_addr_read_from),
    .qwords_to_rd                   (qwords_to_rd),
    .read_chunk_ack                 (read_chunk_ack),
    .tlp_tag                        (tlp_tag),
    .retry_read_chunk               (retry_read_chunk),
    .retry_huge_page_addr_read_from (retry_huge_page_addr_read_from),
    .retry_tlp_tag                  (retry_tlp_tag),
    .retry_dwords_to_rd             (retry_dwords_to_rd),
    .retry_read_chunk_ack           (retry_read_chunk_ack),
    .tag_release                    (tag_release),
    .tag_release_num                (tag_release_num),
    .rd_req                         (rd_req),
    .rd_req_addr                    (rd_req_addr),
    .rd_req_tag                     (rd_req_tag),
    .rd_req_dw                      (rd_req_dw),
    .rd_req_ack                     (rd_req_ack),
    .tags_free                      (tags_free),
    .release_err                    (release_err),
    .retry_grants                   (retry_grants),
    .primary_grants                 (primary_grants)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Acts as the TLP builder: waits (bounded) for rd_req, captures the fields,
  // holds off ack_delay cycles, acks, and returns the state of the ACK cycle.
  task automatic serve(input int ack_delay, output bit ok, output int lat,
                       output logic [63:0] a, output logic [3:0] t,
                       output logic [9:0] dw, output logic pa, output logic ra,
                       output logic [3:0] tt, output logic [4:0] tf);
    ok = 1'b0; lat = 0; a = '0; t = '0; dw = '0; pa = 1'b0; ra = 1'b0;
    tt = '0; tf = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      lat++;
      if (rd_req) ok = 1'b1;
    end
    if (!ok) return;
    a = rd_req_addr; t = rd_req_tag; dw = rd_req_dw;
    repeat (ack_delay) step();
    rd_req_ack = 1'b1;
    step();
    rd_req_ack = 1'b0;
    pa = read_chunk_ack; ra = retry_read_chunk_ack; tt = tlp_tag; tf = tags_free;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    vectors++;
    if (rd_req !== 1'b0 || read_chunk_ack !== 1'b0 || retry_read_chunk_ack !== 1'b0 ||
        release_err !== 1'b0 || tags_free !== 5'd4 || rd_req_addr !== 64'd0 ||
        rd_req_tag !== 4'd0 || rd_req_dw !== 10'd0 || tlp_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: rd_req=%b acks=%b%b err=%b free=%0d addr=%h tag=%0d dw=%0d tlp_tag=%0d, want all zero and free=4",
               rd_req, read_chunk_ack, retry_read_chunk_ack, release_err, tags_free,
               rd_req_addr, rd_req_tag, rd_req_dw, tlp_tag);
    end
    vectors++;
    if (retry_grants !== 32'd0 || primary_grants !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stats: retry=%0d primary=%0d want 0 0", retry_grants, primary_grants);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_primary();
    bit ok; int lat; logic [63:0] a; logic [3:0] t; logic [9:0] dw;
    logic pa, ra; logic [3:0] tt; logic [4:0] tf;
    read_chunk = 1'b1; huge_page_addr_read_from = 64'h1000; qwords_to_rd = 9'd16;
    serve(2, ok, lat, a, t, dw, pa, ra, tt, tf);
    read_chunk = 1'b0;
    vectors++;
    if (!ok || lat != 1) begin
      miscompares++;
      $display("FAIL single_latency: seen=%b cycles=%0d want seen after 1", ok, lat);
    end
    vectors++;
    if (a !== 64'h1000 || t !== 4'd0 || dw !== 10'd32) begin
      miscompares++;
      $display("FAIL single_fields: addr=%h tag=%0d dw=%0d want 1000 0 32", a, t, dw);
    end
    vectors++;
    if (pa !== 1'b1 || ra !== 1'b0 || tt !== 4'd0 || tf !== 5'd3) begin
      miscompares++;
      $display("FAIL single_ack: pack=%b rack=%b tlp_tag=%0d free=%0d want 1 0 0 3", pa, ra, tt, tf);
    end
    step();
    vectors++;
    if (read_chunk_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack_pulse: read_chunk_ack=%b want 0 after one cycle", read_chunk_ack);
    end
`ifdef TX_RD_ARB_STATS_EN
    vectors++;
    if (primary_grants !== 32'd1 || retry_grants !== 32'd0) begin
      miscompares++;
      $display("FAIL single_stats: primary=%0d retry=%0d want 1 0", primary_grants, retry_grants);
    end
`endif
    step();
  endtask

  task automatic test_retry_passthrough();
    bit ok; int lat; logic [63:0] a; logic [3:0] t; logic [9:0] dw;
    logic pa, ra; logic [3:0] tt; logic [4:0] tf;
    retry_read_chunk = 1'b1; retry_huge_page_addr_read_from = 64'h2008;
    retry_tlp_tag = 4'd1; retry_dwords_to_rd = 10'd6;
    serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
    retry_read_chunk = 1'b0;
    vectors++;
    if (!ok || a !== 64'h2008 || t !== 4'd1 || dw !== 10'd6) begin
      miscompares++;
      $display("FAIL retry_fields: seen=%b addr=%h tag=%0d dw=%0d want 1 2008 1 6", ok, a, t, dw);
    end
    vectors++;
    if (ra !== 1'b1 || pa !== 1'b0 || tf !== 5'd3) begin
      miscompares++;
      $display("FAIL retry_ack: rack=%b pack=%b free=%0d want 1 0 3", ra, pa, tf);
    end
    step();
    step();
  endtask

  task automatic test_release_err();
    tag_release = 1'b1; tag_release_num = 4'd3;
    step();
    tag_release = 1'b0;
    vectors++;
    if (release_err !== 1'b1 || tags_free !== 5'd3) begin
      miscompares++;
      $display("FAIL release_free_tag: err=%b free=%0d want 1 3", release_err, tags_free);
    end
    repeat (3) step();
    vectors++;
    if (release_err !== 1'b1) begin
      miscompares++;
      $display("FAIL release_err_sticky: err=%b want 1", release_err);
    end
    tag_release = 1'b1; tag_release_num = 4'd0;
    step();
    tag_release = 1'b0;
    vectors++;
    if (tags_free !== 5'd4) begin
      miscompares++;
      $display("FAIL release_busy_tag: free=%0d want 4", tags_free);
    end
    tag_release = 1'b1; tag_release_num = 4'd9;
    step();
    tag_release = 1'b0;
    vectors++;
    if (tags_free !== 5'd4 || release_err !== 1'b1) begin
      miscompares++;
      $display("FAIL release_out_of_range: free=%0d err=%b want 4 1", tags_free, release_err);
    end
  endtask

  task automatic test_pool_exhaustion();
    bit ok; int lat; logic [63:0] a; logic [3:0] t; logic [9:0] dw;
    logic pa, ra; logic [3:0] tt; logic [4:0] tf;
    int seen;
    for (int k = 0; k < 4; k++) begin
      read_chunk = 1'b1; huge_page_addr_read_from = 64'(k) * 64'h100;
      qwords_to_rd = 9'(k + 1);
      serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
      read_chunk = 1'b0;
      vectors++;
      if (!ok || t !== 4'(k) || tt !== 4'(k) || pa !== 1'b1 ||
          tf !== 5'(3 - k) || dw !== 10'(2 * (k + 1))) begin
        miscompares++;
        $display("FAIL exhaust_grant%0d: seen=%b tag=%0d tlp_tag=%0d pack=%b free=%0d dw=%0d want 1 %0d %0d 1 %0d %0d",
                 k, ok, t, tt, pa, tf, dw, k, k, 3 - k, 2 * (k + 1));
      end
      step();
      step();
    end
    read_chunk = 1'b1; huge_page_addr_read_from = 64'h4000; qwords_to_rd = 9'd0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_req || read_chunk_ack) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL exhaust_held_off: active cycles=%0d want 0", seen);
    end
    // Retry is still served while the pool is empty
    retry_read_chunk = 1'b1; retry_huge_page_addr_read_from = 64'h5000;
    retry_tlp_tag = 4'd3; retry_dwords_to_rd = 10'd2;
    serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
    retry_read_chunk = 1'b0;
    vectors++;
    if (!ok || ra !== 1'b1 || pa !== 1'b0 || t !== 4'd3 || tf !== 5'd0) begin
      miscompares++;
      $display("FAIL exhaust_retry_served: seen=%b rack=%b pack=%b tag=%0d free=%0d want 1 1 0 3 0",
               ok, ra, pa, t, tf);
    end
    step();
    step();
    tag_release = 1'b1; tag_release_num = 4'd2;
    step();
    tag_release = 1'b0;
    vectors++;
    if (tags_free !== 5'd1) begin
      miscompares++;
      $display("FAIL exhaust_release: free=%0d want 1", tags_free);
    end
    serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
    read_chunk = 1'b0;
    vectors++;
    if (!ok || t !== 4'd2 || tt !== 4'd2 || pa !== 1'b1 || tf !== 5'd0 || dw !== 10'd0) begin
      miscompares++;
      $display("FAIL exhaust_reuse: seen=%b tag=%0d tlp_tag=%0d pack=%b free=%0d dw=%0d want 1 2 2 1 0 0",
               ok, t, tt, pa, tf, dw);
    end
    step();
    step();
  endtask

  task automatic test_starvation();
    bit ok; int lat; logic [63:0] a; logic [3:0] t; logic [9:0] dw;
    logic pa, ra; logic [3:0] tt; logic [4:0] tf;
    logic [5:0] exp_retry;
    int prim_n;
    exp_retry = 6'b110110; // grant k expects retry when bit (5-k) is set
    prim_n = 0;
    read_chunk = 1'b1; huge_page_addr_read_from = 64'h6000; qwords_to_rd = 9'd4;
    retry_read_chunk = 1'b1; retry_huge_page_addr_read_from = 64'h7000;
    retry_tlp_tag = 4'd3; retry_dwords_to_rd = 10'd8;
    for (int k = 0; k < 6; k++) begin
      serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
      vectors++;
      if (!ok || ra !== exp_retry[5-k] || pa !== ~exp_retry[5-k]) begin
        miscompares++;
        $display("FAIL starve_order%0d: seen=%b rack=%b pack=%b want rack=%b",
                 k, ok, ra, pa, exp_retry[5-k]);
      end
      if (!exp_retry[5-k]) begin
        vectors++;
        if (tt !== 4'(prim_n)) begin
          miscompares++;
          $display("FAIL starve_tag%0d: tlp_tag=%0d want %0d", k, tt, prim_n);
        end
        prim_n++;
      end
      step();
      step();
    end
    read_chunk = 1'b0;
    retry_read_chunk = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_transfer();
    bit ok; int lat; logic [63:0] a; logic [3:0] t; logic [9:0] dw;
    logic pa, ra; logic [3:0] tt; logic [4:0] tf;
`ifdef TX_RD_ARB_STATS_EN
    vectors++;
    if (retry_grants !== 32'd4 || primary_grants !== 32'd2) begin
      miscompares++;
      $display("FAIL stats_count: retry=%0d primary=%0d want 4 2", retry_grants, primary_grants);
    end
`endif
    read_chunk = 1'b1; huge_page_addr_read_from = 64'h8000; qwords_to_rd = 9'd1;
    step();
    vectors++;
    if (rd_req !== 1'b1 || rd_req_tag !== 4'd2) begin
      miscompares++;
      $display("FAIL midreset_pre: rd_req=%b tag=%0d want 1 2", rd_req, rd_req_tag);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (rd_req !== 1'b0 || tags_free !== 5'd4 || release_err !== 1'b0 || rd_req_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_async: rd_req=%b free=%0d err=%b tag=%0d want 0 4 0 0",
               rd_req, tags_free, release_err, rd_req_tag);
    end
    vectors++;
    if (retry_grants !== 32'd0 || primary_grants !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_stats: retry=%0d primary=%0d want 0 0", retry_grants, primary_grants);
    end
    step();
    reset = 1'b0;
    // FSM back in IDLE with a full pool: the held request is granted tag 0 next cycle
    serve(0, ok, lat, a, t, dw, pa, ra, tt, tf);
    read_chunk = 1'b0;
    vectors++;
    if (!ok || lat != 1 || t !== 4'd0 || pa !== 1'b1 || tf !== 5'd3) begin
      miscompares++;
      $display("FAIL midreset_regrant: seen=%b cycles=%0d tag=%0d pack=%b free=%0d want 1 1 0 1 3",
               ok, lat, t, pa, tf);
    end
    step();
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    read_chunk = 1'b0; huge_page_addr_read_from = 64'd0; qwords_to_rd = 9'd0;
    retry_read_chunk = 1'b0; retry_huge_page_addr_read_from = 64'd0;
    retry_tlp_tag = 4'd0; retry_dwords_to_rd = 10'd0;
    tag_release = 1'b0; tag_release_num = 4'd0; rd_req_ack = 1'b0;

    test_reset();
    test_single_primary();
    test_retry_passthrough();
    test_release_err();
    do_reset();
    test_pool_exhaustion();
    do_reset();
    test_starvation();
    test_reset_mid_transfer();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
